// File: rtl/keep_m_in_n.sv
// keep_m_in_n: forwards m of every n samples (sample mode) or packets (vector mode) on an AXI-stream.
// Define KEEP_M_IN_N_STATS_EN to build the saturating keep/drop beat counters.
module keep_m_in_n #(
  parameter int WIDTH = 32,
  parameter int MAX_N = 65535,
  localparam int WN = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             vector_mode,
  input  logic [WN-1:0]    m,
  input  logic [WN-1:0]    n,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [31:0]      drop_count,
  output logic [31:0]      keep_count
);

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // valid never waits for ready, and a presented output beat is held until taken.

  localparam logic [WN-1:0] ONE = WN'(1);

  logic [WN-1:0]    cfg_m, cfg_n;
  logic [WN-1:0]    act_m, act_n;
  logic             act_vec;
  logic [WN-1:0]    eff_m, eff_n;
  logic             eff_vec;
  logic [WN-1:0]    samp_cnt, pkt_cnt;
  logic             sop;
  logic             started;
  logic             boundary;
  logic             last_samp, last_pkt;
  logic             keep_now;
  logic             fire, push, pop;
  logic             out_last;
  logic [1:0]       fill;
  logic [WIDTH-1:0] data0, data1;
  logic             last0, last1;

  always_comb begin
    cfg_n = (n == '0) ? ONE : n;
    cfg_m = (m == '0) ? ONE : ((m > cfg_n) ? cfg_n : m);
  end

  // At a window boundary the incoming settings govern the first item directly.
  assign boundary  = act_vec ? (pkt_cnt == '0 && sop) : (samp_cnt == '0);
  assign eff_m     = boundary ? cfg_m : act_m;
  assign eff_n     = boundary ? cfg_n : act_n;
  assign eff_vec   = boundary ? vector_mode : act_vec;

  assign last_samp = (samp_cnt >= eff_n - ONE);
  assign last_pkt  = (pkt_cnt >= eff_n - ONE);
  assign keep_now  = eff_vec ? (pkt_cnt < eff_m) : (samp_cnt < eff_m);
  assign out_last  = eff_vec ? i_tlast : (i_tlast && last_pkt);

  // Dropped beats never need buffer space, so they are taken even when full.
  assign i_tready  = started && ((fill != 2'd2) || !keep_now);
  assign fire      = i_tvalid && i_tready;
  assign push      = fire && keep_now && !clear;
  assign pop       = (fill != 2'd0) && o_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started  <= 1'b0;
      samp_cnt <= '0;
      pkt_cnt  <= '0;
      sop      <= 1'b1;
      act_m    <= ONE;
      act_n    <= ONE;
      act_vec  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clear) begin
        samp_cnt <= '0;
        pkt_cnt  <= '0;
        sop      <= 1'b1;
        act_m    <= cfg_m;
        act_n    <= cfg_n;
        act_vec  <= vector_mode;
      end else begin
        if (boundary) begin
          act_m   <= cfg_m;
          act_n   <= cfg_n;
          act_vec <= vector_mode;
        end
        if (fire) begin
          sop <= i_tlast;
          if (eff_vec) samp_cnt <= '0;
          else         samp_cnt <= last_samp ? '0 : samp_cnt + ONE;
          if (i_tlast) pkt_cnt <= last_pkt ? '0 : pkt_cnt + ONE;
        end
      end
    end
  end

  // Two-entry output buffer; entry 0 always drives the output port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill  <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
    end else if (clear) begin
      fill <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fill == 2'd0) begin
            data0 <= i_tdata;
            last0 <= out_last;
          end else begin
            data1 <= i_tdata;
            last1 <= out_last;
          end
          fill <= fill + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          fill  <= fill - 2'd1;
        end
        2'b11: begin
          if (fill == 2'd1) begin
            data0 <= i_tdata;
            last0 <= out_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= i_tdata;
            last1 <= out_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_tvalid = (fill != 2'd0);
  assign o_tdata  = data0;
  assign o_tlast  = last0;

`ifdef KEEP_M_IN_N_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keep_count <= '0;
      drop_count <= '0;
    end else if (clear) begin
      keep_count <= '0;
      drop_count <= '0;
    end else begin
      if (push && (keep_count != '1)) keep_count <= keep_count + 32'd1;
      if (fire && !keep_now && (drop_count != '1)) drop_count <= drop_count + 32'd1;
    end
  end
`else
  assign keep_count = '0;
  assign drop_count = '0;
`endif

endmodule
